// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    IWAIT = 2'b01,
    DWAIT = 2'b10,
    ERR   = 2'b11
  } CTRL_STATE;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } FWD_SEL;

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// EX-stage operand forwarding compare; MEM result beats WB result, x0 never forwarded.
module fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output FWD_SEL           fwd_a,
  output FWD_SEL           fwd_b
);

  function automatic FWD_SEL pick(input logic [REG_W-1:0] rs);
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign fwd_a = pick(ex_rs1);
  assign fwd_b = pick(ex_rs2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stage enables/flushes,
// forwarding selects, memory-wait freeze with watchdog, and stall statistics.
//
// state | meaning
// RUN   | normal flow, hazards resolved combinationally
// IWAIT | instruction fetch outstanding, front end held
// DWAIT | data access outstanding, whole pipeline frozen
// ERR   | memory watchdog expired, pipeline held until reset
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_branch_taken,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             dmem_req,
  output logic [1:0]       state,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  CTRL_STATE        state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic             flush_pending_q, flush_pending_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             dfreeze, ifreeze, load_use, branch_now, stall_any;
  FWD_SEL           fwd_a_raw, fwd_b_raw;

  fwd_unit u_fwd (
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  // A pending branch flush suppresses new requests, but an access already
  // waiting in DWAIT is always carried to completion.
  assign dmem_req = rst_n && (mem_read || mem_write) && (state_q != ERR)
                    && !(flush_pending_q && (state_q != DWAIT));
  assign dfreeze    = dmem_req && !dmem_ready;
  assign ifreeze    = !imem_ready && !dfreeze && (state_q != ERR);
  assign branch_now = mem_branch_taken || flush_pending_q;
  assign load_use   = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign fwd_a = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b = rst_n ? fwd_b_raw : FWD_RF;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush, ex_mem_flush}          = '1;
    end else if ((state_q == ERR) || dfreeze) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
    end else if (branch_now) begin
      {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
    end else if (ifreeze || load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign stall_any = !(pc_en && if_id_en && id_ex_en && ex_mem_en && mem_wb_en);

  always_comb begin
    state_d         = state_q;
    wait_d          = '0;
    flush_pending_d = flush_pending_q;
    unique case (state_q)
      RUN:   if (dfreeze) state_d = DWAIT;
             else if (ifreeze) state_d = IWAIT;
      IWAIT: if (dfreeze) state_d = DWAIT;
             else if (imem_ready) state_d = RUN;
      DWAIT: if (!dfreeze) state_d = RUN;
      ERR:   state_d = ERR;
      default: state_d = RUN;
    endcase
    if (((state_q == IWAIT) || (state_q == DWAIT)) && (state_d != RUN)) begin
      wait_d = wait_q + 16'd1;
      if (wait_d >= 16'(MEM_TIMEOUT)) state_d = ERR;
    end
    if (dfreeze && mem_branch_taken) flush_pending_d = 1'b1;
    else if (!dfreeze)               flush_pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      wait_q          <= '0;
      flush_pending_q <= 1'b0;
      bus_err         <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      wait_q          <= wait_d;
      flush_pending_q <= flush_pending_d;
      if (state_d == ERR) bus_err <= 1'b1;
      if (stall_any && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: combinational vector table plus multi-cycle sequences.
module tb_pipeline_ctrl;

  logic       clk, rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_mem_read, mem_reg_write, mem_read, mem_write, mem_branch_taken;
  logic       wb_reg_write, imem_ready, dmem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] fwd_a, fwd_b, state;
  logic       dmem_req, bus_err;
  logic [3:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_branch_taken(mem_branch_taken),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_req(dmem_req),
    .state(state), .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ex_mem_read;
    logic [4:0] ex_rd, id_rs1, id_rs2, ex_rs1, ex_rs2, mem_rd;
    logic       mem_reg_write, mem_read, mem_write, br;
    logic [4:0] wb_rd;
    logic       wb_reg_write, imem_ready, dmem_ready;
    logic [4:0] en;
    logic [2:0] fl;
    logic [1:0] fa, fb;
    logic       req;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [4:0] en_bus();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  endfunction

  function automatic logic [2:0] fl_bus();
    return {if_id_flush, id_ex_flush, ex_mem_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_mem_read, mem_reg_write, mem_read, mem_write, mem_branch_taken, wb_reg_write} = '0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    // name, exmr, ex_rd, id_rs1, id_rs2, ex_rs1, ex_rs2, mem_rd, mrw, mem_read, mem_write, br,
    // wb_rd, wbrw, imem_rdy, dmem_rdy, en{pc,ifid,idex,exmem,memwb}, fl{ifid,idex,exmem}, fa, fb, req
    vecs[0]  = '{"idle",        1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{"lu_rs1",      1'b1, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0};
    vecs[2]  = '{"lu_rs2",      1'b1, 5'd5, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0};
    vecs[3]  = '{"lu_x0",       1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0};
    vecs[4]  = '{"no_load",     1'b0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0};
    vecs[5]  = '{"lu_miss",     1'b1, 5'd6, 5'd5, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0};
    vecs[6]  = '{"branch",      1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b111, 2'b00, 2'b00, 1'b0};
    vecs[7]  = '{"br_over_lu",  1'b1, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b111, 2'b00, 2'b00, 1'b0};
    vecs[8]  = '{"fwd_mem_pri", 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b10, 2'b00, 1'b0};
    vecs[9]  = '{"fwd_x0",      1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0};
    vecs[10] = '{"fwd_wb_b",    1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b01, 1'b0};
    vecs[11] = '{"fwd_nowrite", 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd8, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0};
    vecs[12] = '{"fwd_both",    1'b0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b10, 2'b01, 1'b0};
    vecs[13] = '{"dmem_rd_rdy", 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b00, 1'b1};
    vecs[14] = '{"dmem_wr_rdy", 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b00, 1'b1};

    // Outputs while held in reset, with active-looking inputs.
    rst_n = 1'b0;
    clear_inputs();
    mem_read = 1'b1; ex_rs1 = 5'd7; mem_rd = 5'd7; mem_reg_write = 1'b1;
    #3;
    chk("rst_en",    32'(en_bus()), 32'h00);
    chk("rst_fl",    32'(fl_bus()), 32'h7);
    chk("rst_fwd",   32'({fwd_a, fwd_b}), 32'h0);
    chk("rst_req",   32'(dmem_req), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_berr",  32'(bus_err), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      ex_mem_read = vecs[i].ex_mem_read; ex_rd = vecs[i].ex_rd;
      id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2;
      ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2;
      mem_rd = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_reg_write;
      mem_read = vecs[i].mem_read; mem_write = vecs[i].mem_write;
      mem_branch_taken = vecs[i].br;
      wb_rd = vecs[i].wb_rd; wb_reg_write = vecs[i].wb_reg_write;
      imem_ready = vecs[i].imem_ready; dmem_ready = vecs[i].dmem_ready;
      #1;
      chk(vecs[i].name, 32'({en_bus(), fl_bus(), fwd_a, fwd_b, dmem_req}),
          32'({vecs[i].en, vecs[i].fl, vecs[i].fa, vecs[i].fb, vecs[i].req}));
      step();
    end

    // Load-use: one bubble, then the dependent instruction forwards from WB.
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
    #1;
    chk("lu_seq_stall", 32'({en_bus(), fl_bus()}), 32'({5'b00111, 3'b010}));
    step();
    clear_inputs();
    ex_rs2 = 5'd5; wb_rd = 5'd5; wb_reg_write = 1'b1;
    #1;
    chk("lu_seq_en",   32'(en_bus()), 32'h1f);
    chk("lu_seq_fwdb", 32'(fwd_b), 32'h1);

    // Data wait of three cycles, then release.
    do_reset();
    mem_read = 1'b1; dmem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("dw_frozen", 32'({en_bus(), fl_bus(), dmem_req}), 32'({5'b00000, 3'b000, 1'b1}));
      if (i > 0) chk("dw_state", 32'(state), 32'h2);
      step();
    end
    dmem_ready = 1'b1;
    #1;
    chk("dw_stall3",  32'(stall_cnt), 32'd3);
    chk("dw_rel_en",  32'({en_bus(), dmem_req}), 32'({5'b11111, 1'b1}));
    step();
    chk("dw_run",     32'(state), 32'h0);
    chk("dw_stall_h", 32'(stall_cnt), 32'd3);

    // Taken branch while frozen: flush deferred to the release cycle.
    do_reset();
    mem_read = 1'b1; dmem_ready = 1'b0; mem_branch_taken = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("brdw_frozen", 32'({en_bus(), fl_bus()}), 32'({5'b00000, 3'b000}));
      step();
    end
    dmem_ready = 1'b1; mem_branch_taken = 1'b0;
    #1;
    chk("brdw_release", 32'({en_bus(), fl_bus()}), 32'({5'b11111, 3'b111}));
    step();
    mem_read = 1'b0;
    #1;
    chk("brdw_after", 32'({en_bus(), fl_bus()}), 32'({5'b11111, 3'b000}));

    // Instruction-fetch watchdog with MEM_TIMEOUT=4.
    do_reset();
    imem_ready = 1'b0;
    #1;
    chk("iw_front", 32'({en_bus(), fl_bus()}), 32'({5'b00111, 3'b010}));
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("iw_state", 32'(state), 32'h1);
    end
    step();
    chk("to_state", 32'(state), 32'h3);
    chk("to_berr",  32'(bus_err), 32'h1);
    imem_ready = 1'b1;
    #1;
    chk("to_en", 32'(en_bus()), 32'h00);
    step();
    chk("to_hold", 32'({state, en_bus()}), 32'({2'b11, 5'b00000}));
    do_reset();
    #1;
    chk("to_clr", 32'({state, bus_err}), 32'h0);

    // Asynchronous reset in the middle of a data wait.
    do_reset();
    mem_read = 1'b1; dmem_ready = 1'b0;
    step();
    step();
    chk("rdw_pre", 32'(state), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("rdw_out",   32'({en_bus(), fl_bus(), fwd_a, fwd_b, dmem_req}), 32'({5'b00000, 3'b111, 5'b00000}));
    chk("rdw_state", 32'({state, stall_cnt}), 32'h0);
    #2 rst_n = 1'b1;
    clear_inputs();

    // Stall counter saturation at CNT_W=4.
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    repeat (20) step();
    chk("stall_sat", 32'(stall_cnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32IC pipeline (IF, ID, EX, MEM, WB).
- Generates per-stage register enables and flushes, EX-stage forwarding selects, and freeze control for multi-cycle instruction- and data-memory handshakes.
- Contains a small FSM that tracks memory waits and a watchdog timeout.
- Consumes the rd/rs/RegWrite/MemRead/MemWrite/branch fields carried in the ID/EX/MEM/WBACK stage state structs.

Parameters:
- MEM_TIMEOUT, 255, maximum consecutive wait cycles on either memory before a bus error is declared (1..65535).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock (all state updates on rising edge)
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- ex_rs1, ex_rs2  in  5  source registers of the instruction in EX
- ex_rd  in  5  EX destination register
- ex_mem_read  in  1  EX instruction is a load
- mem_rd  in  5  MEM destination register
- mem_reg_write  in  1  MEM instruction writes the register file
- mem_read, mem_write  in  1  MEM instruction accesses data memory
- mem_branch_taken  in  1  MEM stage resolved a taken branch/jump (BranchSrc0)
- wb_rd  in  5  WB destination register
- wb_reg_write  in  1  WB instruction writes the register file
- imem_ready  in  1  instruction memory returns data this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load a bubble (all control bits 0) into that register
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB result, 10 MEM ALUOutput
- dmem_req  out  1  data memory request
- state  out  2  FSM state
- bus_err  out  1  sticky timeout error
- stall_cnt  out  CNT_W  cycles with any enable deasserted

Behaviour:
- States: RUN=00, IWAIT=01, DWAIT=10, ERR=11. Reset puts the FSM in RUN, clears the wait counter and stall_cnt, and clears bus_err.
- While rst_n=0:
  - All enables are 0.
  - All flushes are 1.
  - fwd_a/fwd_b are 00.
  - dmem_req is 0.
  - A reset asserted mid-wait abandons the access with no retry.
- dmem_req = (mem_read|mem_write) & ~flush_pending & state≠ERR. It is combinational and is held for the whole wait.
- dfreeze = dmem_req & ~dmem_ready. When dfreeze=1, all five enables are 0 and all flushes are 0; the pipeline is frozen completely.
- ifreeze = ~imem_ready & ~dfreeze. When ifreeze=1:
  - pc_en=0 and if_id_en=0.
  - id_ex_flush=1 if the ID slot is consumed, i.e. the younger stages keep running and a bubble is inserted at ID/EX.
  - dmem wait has priority over imem wait.
- Load-use: ex_mem_read & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2). It applies when no freeze and no branch flush is active, and gives:
  - pc_en=0, if_id_en=0, id_ex_flush=1.
  - Exactly one bubble per hazard.
- Taken branch (mem_branch_taken, no dfreeze):
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1; the PC is loaded with the target.
  - Branch beats load-use and ifreeze.
  - If the branch arrives during dfreeze, flush_pending is set and the flush is applied on the first unfrozen cycle.
- Forwarding (combinational), for X in {a,b} using ex_rs1/ex_rs2:
  - 10 if mem_reg_write & mem_rd≠0 & mem_rd==ex_rsX.
  - Else 01 if wb_reg_write & wb_rd≠0 & wb_rd==ex_rsX.
  - Else 00.
  - MEM has priority over WB; x0 is never forwarded.
- FSM transitions:
  - RUN→DWAIT on dfreeze; RUN→IWAIT on ifreeze.
  - DWAIT→RUN on dmem_ready.
  - IWAIT→RUN on imem_ready, or →DWAIT if dfreeze arises.
  - Wait counter: incremented each cycle in IWAIT/DWAIT, cleared on return to RUN.
  - Timeout: reaching MEM_TIMEOUT goes →ERR and sets bus_err.
  - ERR holds all enables at 0 until reset.
- stall_cnt increments on any cycle with any enable=0 outside reset. It saturates at all-ones with no wrap.

Decomposition:
- Add to package PipelineReg:
  - typedef enum logic[1:0] CTRL_STATE {RUN, IWAIT, DWAIT, ERR}.
  - typedef enum logic[1:0] FWD_SEL {FWD_RF=00, FWD_WB=01, FWD_MEM=10}.
- Sub-module fwd_unit is purely combinational and contains only the forwarding compare. It is instantiated once, with ports a and b computed in parallel.
- Hazard priority, FSM and counters stay in pipeline_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1 and fwd_b=01 for the dependent instruction.
- Forwarding priority: mem_rd=wb_rd=ex_rs1=7, both writes=1 → fwd_a=10. With ex_rs1=0 and mem_rd=0 → fwd_a=00.
- Data wait: mem_read=1, dmem_ready low for 3 cycles → all enables 0 for 3 cycles, state=DWAIT, stall_cnt=3. Ready → RUN, enables 1.
- Branch during dwait: mem_branch_taken=1 with dmem_ready=0 for 2 cycles → no flush while frozen; the three flushes are asserted on the release cycle.
- Timeout: MEM_TIMEOUT=4, imem_ready=0 → ERR after 4 wait cycles, bus_err=1, enables 0 until rst_n pulse; after reset state=RUN and bus_err=0.
- Reset mid-DWAIT and stall_cnt saturation: assert rst_n=0 asynchronously mid-DWAIT → enables 0, flushes 1 immediately. With CNT_W=4, 20 stall cycles → stall_cnt=15.
